// File: rtl/ones_counter_seq.sv
// Sequential population counter: BITS_PER_CYCLE bits per clock under a start/busy/done handshake.
// Optional registered strict-majority output enabled by defining ONES_COUNTER_MAJORITY_EN.
module ones_counter_seq #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned CW             = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count
`ifdef ONES_COUNTER_MAJORITY_EN
  ,
  output logic             majority
`endif
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = $clog2(BITS_PER_CYCLE + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("ones_counter_seq: WIDTH must be >= 1");
    end
    if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
      $error("ones_counter_seq: BITS_PER_CYCLE must divide WIDTH exactly");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    acc;
  logic [BW-1:0]    beat;
  logic [PW-1:0]    part;
  logic [CW-1:0]    sum;
  logic             last;

  // Popcount of the low slice about to be shifted out this beat.
  always_comb begin
    part = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      part = part + PW'(shreg[i]);
    end
  end

  always_comb begin
    sum  = acc + CW'(part);
    last = (beat == BW'(N - 1));
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      acc   <= '0;
      beat  <= '0;
      count <= '0;
`ifdef ONES_COUNTER_MAJORITY_EN
      majority <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= din;
            acc   <= '0;
            beat  <= '0;
            state <= COUNT;
          end
        end
        COUNT: begin
          acc   <= sum;
          shreg <= shreg >> BITS_PER_CYCLE;
          beat  <= beat + 1'b1;
          if (last) begin
            count <= sum;
`ifdef ONES_COUNTER_MAJORITY_EN
            majority <= (sum > CW'(WIDTH / 2));
`endif
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ones_counter_seq.md
Name: ones_counter_seq

Overview:
- Parametrised, sequential successor to the 3-input combinational ones counter.
- Counts the set bits of a WIDTH-bit word, processing BITS_PER_CYCLE bits per clock, under a start/busy/done handshake.
- Used where a wide population count is needed and a full combinational adder tree is too large; trades latency for area.

Parameters:
- WIDTH, 8, width of the input word in bits; must be >= 1.
- BITS_PER_CYCLE, 1, bits consumed per COUNT cycle; must divide WIDTH exactly (elaboration-time check, $error if violated).
- CW, $clog2(WIDTH+1), width of count output; derived, not to be overridden.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- din  input  WIDTH  word to count; captured on the accepted start edge only.
- busy  output  1  high in COUNT and DONE states.
- done  output  1  one-cycle pulse; count valid while high.
- count  output  CW  number of 1 bits in the last captured word; holds until the next result.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0; done=0; count=0; internal shift register and accumulator cleared.
  - rst has priority over all other inputs, including in mid-operation: an in-flight count is abandoned and no done pulse is issued.
- Let N = WIDTH/BITS_PER_CYCLE.
- FSM states IDLE, COUNT, DONE:
  - IDLE: if start=1 at edge E0, load shift register with din, clear accumulator, go to COUNT with beat counter = 0. Otherwise stay in IDLE.
  - COUNT: at each edge, add the popcount of shift register bits [BITS_PER_CYCLE-1:0] to the accumulator, then shift right by BITS_PER_CYCLE and increment the beat counter.
    - On the Nth COUNT edge (EN), load count with the final sum and go to DONE.
  - DONE: done=1 for exactly this one cycle; at the next edge go to IDLE.
- Latency:
  - start accepted at E0; done high in the cycle after EN, i.e. N cycles after the accepting edge.
  - Next start accepted at E(N+2) at the earliest.
- start while busy (COUNT or DONE): ignored. No queueing; din is not re-captured.
- din changes after capture: no effect on the in-flight result.
- count changes only on the EN edge or on reset; it is stable between results.
- Arithmetic:
  - Accumulator is CW bits wide; it cannot overflow because its maximum value is WIDTH.
  - Per-cycle partial sum is a $clog2(BITS_PER_CYCLE+1)-bit popcount, zero-extended to CW.
- Degenerate case BITS_PER_CYCLE=WIDTH: N=1, single COUNT cycle, done one cycle after acceptance.

Optional Feature:
- Macro ONES_COUNTER_MAJORITY_EN.
- When defined:
  - Adds output port majority (1 bit).
  - majority is registered and updated on the same edge as count: 1 iff count > WIDTH/2 using integer division (strict majority; for even WIDTH, an exact half yields 0).
  - Reset value 0; holds between results like count.
- When undefined: port absent; no majority logic synthesised.

Test Plan:
- WIDTH=8, BPC=1: start with din=8'b1011_0010 -> busy for 9 cycles, done pulse 8 cycles after acceptance, count=4; then din=8'h00 -> 0 and din=8'hFF -> 8.
- WIDTH=8, BPC=2: din=8'hA5 -> done 4 cycles after acceptance, count=4. BPC=8: din=8'h7F -> count=7, 1 cycle after acceptance.
- WIDTH=3, BPC=1, all 8 input combinations applied as in the combinational ones-counter bench (000,100,110,111,101,001,011,010) -> count equals the combinational {y1,y0} each time: 0,1,2,3,2,1,2,1.
- Handshake: start held high continuously with din changing every cycle (8'hFF then 8'h01) -> only the first word counted, count=8; the next acceptance occurs exactly at E(N+2).
- Reset mid-op: assert rst on the 3rd COUNT edge after din=8'hFF -> busy=0, count=0, no done pulse; a subsequent start with din=8'h0F -> count=4.
- ONES_COUNTER_MAJORITY_EN, WIDTH=8: din=8'hF1 -> count=5, majority=1; din=8'hF0 -> count=4, majority=0; with the macro undefined, the build succeeds without the port.
